// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: md_op encodings, default latencies, start-op helpers.
// MDU_MADD_EN adds MADD/MADDU to the set of accepted start operations.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_start_op(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Ops that take the multiplier latency rather than the divider latency.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MADDU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply/divide/accumulate result ({hi,lo}) plus divide-by-zero flag.
// MDU_MADD_EN enables the MADD/MADDU accumulate paths.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div_by_zero
);

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s, b_s, quot_s, rem_s;
  logic               div_ovf;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign a_s    = a;
  assign b_s    = b;

  // The one signed quotient that does not fit in 32 bits is forced explicitly.
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    quot_s = '0;
    rem_s  = '0;
    if (b != 32'd0 && !div_ovf) begin
      quot_s = a_s / b_s;
      rem_s  = a_s % b_s;
    end else if (div_ovf) begin
      quot_s = 32'sh8000_0000;
    end
  end

  always_comb begin
    res         = {hi, lo};
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        res         = {rem_s, quot_s};
        div_by_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        if (b != 32'd0) res = {a % b, a / b};
        div_by_zero = (b == 32'd0);
      end
`ifdef MDU_MADD_EN
      MD_MADD:  res = {hi, lo} + prod_s;
      MD_MADDU: res = {hi, lo} + prod_u;
`endif
      default: res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit with HI/LO registers, fixed-latency busy window and mfhi/mflo readout.
// MDU_MADD_EN: accept MADD/MADDU (accumulate into {hi,lo}) with the multiply latency.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] multdiv_res
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   temp_hi, temp_lo;
  logic          commit;
  logic [63:0]   arith_res;
  logic          div_by_zero;

  mdu_arith u_arith (
    .op          (md_op),
    .a           (rs_data),
    .b           (rt_data),
    .hi          (hi),
    .lo          (lo),
    .res         (arith_res),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
      commit  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (busy) begin
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        cnt  <= '0;
        // A divide by zero runs the full window but leaves hi/lo untouched.
        if (commit) begin
          hi <= temp_hi;
          lo <= temp_lo;
        end
      end else begin
        cnt <= cnt - CW'(1);
      end
    end else if (start && is_md_start_op(md_op)) begin
      {temp_hi, temp_lo} <= arith_res;
      commit <= !div_by_zero;
      busy   <= 1'b1;
      cnt    <= is_mul_op(md_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (!start) begin
      if (md_op == MD_MTHI) hi <= rs_data;
      if (md_op == MD_MTLO) lo <= rs_data;
    end
  end

  always_comb begin
    multdiv_res = 32'd0;
    if (md_op == MD_MFHI) multdiv_res = hi;
    else if (md_op == MD_MFLO) multdiv_res = lo;
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomised self-checking bench for mdu_hilo against a plain-arithmetic HI/LO model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo, multdiv_res;

  int tests = 0;
  int fails = 0;
  logic [63:0] m_hilo;

  mdu_hilo dut (
    .clk(clk), .reset(reset), .md_op(md_op), .start(start),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy),
    .hi(hi), .lo(lo), .multdiv_res(multdiv_res)
  );

  always #5 clk = ~clk;

  // Returns {commit, new {hi,lo}} for a start op from 64-bit integer arithmetic.
  function automatic logic [64:0] model_op(input logic [3:0] op, input logic [31:0] a, b,
                                           input logic [63:0] cur);
    longint sa, sb, ua, ub;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      MD_MULT:  return {1'b1, 64'(sa * sb)};
      MD_MULTU: return {1'b1, 64'(ua * ub)};
      MD_DIV: begin
        if (b == 0) return {1'b0, cur};
        q = 64'(sa / sb);
        r = 64'(sa % sb);
        return {1'b1, r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return {1'b0, cur};
        q = 64'(ua / ub);
        r = 64'(ua % ub);
        return {1'b1, r[31:0], q[31:0]};
      end
`ifdef MDU_MADD_EN
      MD_MADD:  return {1'b1, cur + 64'(sa * sb)};
      MD_MADDU: return {1'b1, cur + 64'(ua * ub)};
`endif
      default:  return {1'b0, cur};
    endcase
  endfunction

  function automatic int expected_lat(input logic [3:0] op);
    if (op == MD_DIV || op == MD_DIVU) return 10;
`ifdef MDU_MADD_EN
    if (op == MD_MADD || op == MD_MADDU) return 5;
`endif
    if (op == MD_MULT || op == MD_MULTU) return 5;
    return 0;
  endfunction

  // Pulses start in one cycle, scrambles operands while busy, returns busy cycle count.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, b, output int cycles);
    logic [64:0] m;
    m = model_op(op, a, b, m_hilo);
    if (m[64]) m_hilo = m[63:0];
    md_op = op; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      rs_data = $urandom; rt_data = $urandom;
      cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
    md_op = op; rs_data = a; start = 1'b0;
    @(posedge clk); #1;
    if (op == MD_MTHI) m_hilo[63:32] = a;
    if (op == MD_MTLO) m_hilo[31:0] = a;
    md_op = MD_NONE;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_hilo = '0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_hilo got %h_%h want 0", hi, lo); end
    md_op = MD_MFHI; #1;
    tests++; if (multdiv_res !== 32'd0) begin fails++; $display("FAIL reset_mfhi got %h want 0", multdiv_res); end
    md_op = MD_NONE;
  endtask

  task automatic test_mult;
    int c;
    do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, c);
    tests++; if (c != 5) begin fails++; $display("FAIL mult_busy got %0d want 5", c); end
    tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin fails++; $display("FAIL mult_res got %h_%h want ffffffff_fffffffa", hi, lo); end
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c);
    tests++; if (c != 5) begin fails++; $display("FAIL multu_busy got %0d want 5", c); end
    tests++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin fails++; $display("FAIL multu_res got %h_%h want fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_div;
    int c;
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, c);
    tests++; if (c != 10) begin fails++; $display("FAIL div_busy got %0d want 10", c); end
    tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin fails++; $display("FAIL div_res got %h_%h want ffffffff_fffffffd", hi, lo); end
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c);
    tests++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin fails++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); end
  endtask

  task automatic test_div_zero;
    int c;
    do_mt(MD_MTHI, 32'h11);
    do_mt(MD_MTLO, 32'h22);
    do_op(MD_DIVU, 32'd7, 32'd0, c);
    tests++; if (c != 10) begin fails++; $display("FAIL divz_busy got %0d want 10", c); end
    tests++; if (hi !== 32'h11 || lo !== 32'h22) begin fails++; $display("FAIL divz_hilo got %h_%h want 00000011_00000022", hi, lo); end
  endtask

  task automatic test_busy_ignore;
    int c;
    md_op = MD_MULT; rs_data = 32'd6; rt_data = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    m_hilo = 64'd42;
    c = 0;
    while (busy === 1'b1 && c < 40) begin
      // Alternate a competing start and an MTHI; both must be dropped.
      start = c[0]; md_op = c[0] ? MD_DIVU : MD_MTHI; rs_data = 32'h55; rt_data = 32'd3;
      c++;
      @(posedge clk); #1;
    end
    start = 1'b0; md_op = MD_NONE;
    tests++; if (c != 5) begin fails++; $display("FAIL ignore_busy got %0d want 5", c); end
    tests++; if ({hi, lo} !== 64'd42) begin fails++; $display("FAIL ignore_res got %h_%h want 0_2a", hi, lo); end
  endtask

  task automatic test_reset_abort;
    md_op = MD_DIVU; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      md_op = MD_MTHI; rs_data = 32'h55; rt_data = $urandom;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; md_op = MD_NONE;
    m_hilo = '0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %0b want 0", busy); end
    tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL abort_hilo got %h_%h want 0", hi, lo); end
    repeat (12) @(posedge clk);
    #1;
    tests++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin fails++; $display("FAIL abort_late got %h_%h busy %0b want 0", hi, lo, busy); end
  endtask

  task automatic test_mtlo_mflo;
    do_mt(MD_MTLO, 32'hABCD);
    md_op = MD_MFLO; #1;
    tests++; if (multdiv_res !== 32'hABCD) begin fails++; $display("FAIL mflo got %h want 0000abcd", multdiv_res); end
    md_op = MD_NONE; #1;
    tests++; if (multdiv_res !== 32'd0) begin fails++; $display("FAIL res_none got %h want 0", multdiv_res); end
  endtask

  task automatic test_madd;
    int c;
    do_mt(MD_MTHI, 32'd0);
    do_mt(MD_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    do_op(MD_MADDU, 32'd1, 32'd1, c);
    tests++; if (c != 5) begin fails++; $display("FAIL maddu_busy got %0d want 5", c); end
    tests++; if (hi !== 32'd1 || lo !== 32'd0) begin fails++; $display("FAIL maddu_res got %h_%h want 00000001_00000000", hi, lo); end
    do_op(MD_MADD, 32'hFFFF_FFFF, 32'd2, c);
    tests++; if ({hi, lo} !== m_hilo) begin fails++; $display("FAIL madd_res got %h_%h want %h", hi, lo, m_hilo); end
`else
    do_op(MD_MADDU, 32'd1, 32'd1, c);
    tests++; if (c != 0) begin fails++; $display("FAIL madd_off_busy got %0d want 0", c); end
    tests++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL madd_off_hilo got %h_%h want 00000000_ffffffff", hi, lo); end
`endif
  endtask

  task automatic test_random;
    int c;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 8));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = b & 32'hF;
        default: ;
      endcase
      if (op == MD_MFHI || op == MD_MFLO) op = MD_NONE;
      if (op == MD_MTHI || op == MD_MTLO || op == MD_NONE) begin
        do_mt(op, a);
      end else begin
        do_op(op, a, b, c);
        tests++; if (c != expected_lat(op)) begin fails++; $display("FAIL rand_busy op %0d got %0d want %0d", op, c, expected_lat(op)); end
      end
      tests++; if ({hi, lo} !== m_hilo) begin fails++; $display("FAIL rand_hilo op %0d a %h b %h got %h_%h want %h", op, a, b, hi, lo, m_hilo); end
    end
    md_op = MD_MFHI; #1;
    tests++; if (multdiv_res !== m_hilo[63:32]) begin fails++; $display("FAIL rand_mfhi got %h want %h", multdiv_res, m_hilo[63:32]); end
    md_op = MD_NONE;
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_busy_ignore;
    test_mtlo_mflo;
    test_madd;
    test_random;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
